// File: rtl/apb_periph_demux_pkg.sv
// Shared types and constants for the APB peripheral demultiplexer.
package apb_periph_demux_pkg;

  // Width of the access-phase watchdog counter (covers TIMEOUT_CYCLES up to 2^16)
  localparam int TO_CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP,
    ERR
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_DECODE  = 2'b01,
    CAUSE_TIMEOUT = 2'b10,
    CAUSE_SLVERR  = 2'b11
  } err_cause_e;

  localparam err_cause_e ERR_CAUSE_NONE    = CAUSE_NONE;
  localparam err_cause_e ERR_CAUSE_DECODE  = CAUSE_DECODE;
  localparam err_cause_e ERR_CAUSE_TIMEOUT = CAUSE_TIMEOUT;
  localparam err_cause_e ERR_CAUSE_SLVERR  = CAUSE_SLVERR;

endpackage

// File: rtl/apb_periph_to_cnt.sv
// Saturating access-phase watchdog counter. Cleared on entry to the slave
// setup phase, counts each access cycle without pready, flags the last
// allowed cycle through expired_o.
module apb_periph_to_cnt
  import apb_periph_demux_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  // Compare in one extra bit so TIMEOUT_CYCLES-1 = 2^16-1 still fits
  localparam logic [TO_CNT_WIDTH:0] LIMIT = (TO_CNT_WIDTH+1)'(TIMEOUT_CYCLES - 1);

  logic [TO_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment and hold at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = ({1'b0, cnt_q} == LIMIT);

endmodule

// File: rtl/apb_periph_demux_to.sv
// APB peripheral demultiplexer with per-slot enable mask, decode-error
// response and an access-phase timeout watchdog. Downstream and upstream
// outputs are all registered.
// Optional sticky error log: define APB_PERIPH_DEMUX_ERR_LOG_EN.
module apb_periph_demux_to
  import apb_periph_demux_pkg::*;
#(
  parameter int                          NB_SLAVES      = 4,
  parameter int                          APB_ADDR_WIDTH = 12,
  parameter int                          APB_DATA_WIDTH = 32,
  parameter int                          SEL_LSB        = 10,
  parameter int                          SEL_WIDTH      = 2,
  parameter logic [NB_SLAVES-1:0]        SLAVE_EN_MASK  = 4'b1100,
  parameter int unsigned                 TIMEOUT_CYCLES = 256,
  parameter logic [APB_DATA_WIDTH-1:0]   ERR_RDATA      = 32'hBADC_AB1E
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  // master side
  input  logic                                     m_psel_i,
  input  logic                                     m_penable_i,
  input  logic                                     m_pwrite_i,
  input  logic [APB_ADDR_WIDTH-1:0]                m_paddr_i,
  input  logic [APB_DATA_WIDTH-1:0]                m_pwdata_i,
  output logic [APB_DATA_WIDTH-1:0]                m_prdata_o,
  output logic                                     m_pready_o,
  output logic                                     m_pslverr_o,
  // slave side
  output logic [NB_SLAVES-1:0]                     s_psel_o,
  output logic                                     s_penable_o,
  output logic                                     s_pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]                s_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]                s_pwdata_o,
  input  logic [NB_SLAVES-1:0][APB_DATA_WIDTH-1:0] s_prdata_i,
  input  logic [NB_SLAVES-1:0]                     s_pready_i,
  input  logic [NB_SLAVES-1:0]                     s_pslverr_i,
  // error log
  output logic                                     err_valid_o,
  output logic [1:0]                               err_cause_o,
  output logic [APB_ADDR_WIDTH-1:0]                err_addr_o,
  input  logic                                     err_clr_i
);

  state_e                      state_q;
  logic [APB_ADDR_WIDTH-1:0]   addr_q;
  logic [APB_DATA_WIDTH-1:0]   wdata_q;
  logic                        write_q;
  logic [SEL_WIDTH-1:0]        idx_q;
  logic [APB_DATA_WIDTH-1:0]   cap_rdata_q;
  logic                        cap_err_q;
  logic [NB_SLAVES-1:0]        s_psel_q;
  logic                        s_penable_q;
  logic                        m_pready_q;
  logic                        m_pslverr_q;
  logic [APB_DATA_WIDTH-1:0]   m_prdata_q;

  logic                        setup_req;
  logic [SEL_WIDTH-1:0]        sel_idx;
  logic                        slot_ok;
  logic [NB_SLAVES-1:0]        sel_onehot;
  logic                        sel_ready;
  logic                        sel_err;
  logic [APB_DATA_WIDTH-1:0]   sel_rdata;
  logic                        to_expired;

  // A master setup phase; psel with penable while idle is ignored
  assign setup_req = m_psel_i & ~m_penable_i;
  assign sel_idx   = m_paddr_i[SEL_LSB +: SEL_WIDTH];

  // Decode the incoming slot index; out-of-range indices match no slot
  always_comb begin
    slot_ok    = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < NB_SLAVES; i++) begin
      if (int'(sel_idx) == i) begin
        slot_ok       = SLAVE_EN_MASK[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Pick the response of the slot being accessed
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NB_SLAVES; i++) begin
      if (int'(idx_q) == i) begin
        sel_ready = s_pready_i[i];
        sel_err   = s_pslverr_i[i];
        sel_rdata = s_prdata_i[i];
      end
    end
  end

  apb_periph_to_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_to_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (state_q == SETUP),
    .en_i      ((state_q == ACCESS) && !sel_ready),
    .expired_o (to_expired)
  );

  // Transfer FSM with registered slave-side and master-side outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      cap_rdata_q <= '0;
      cap_err_q   <= 1'b0;
      s_psel_q    <= '0;
      s_penable_q <= 1'b0;
      m_pready_q  <= 1'b0;
      m_pslverr_q <= 1'b0;
      m_prdata_q  <= '0;
    end else begin
      m_pready_q  <= 1'b0;
      m_pslverr_q <= 1'b0;
      m_prdata_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (setup_req) begin
            addr_q  <= m_paddr_i;
            wdata_q <= m_pwdata_i;
            write_q <= m_pwrite_i;
            idx_q   <= sel_idx;
            if (slot_ok) begin
              // slave setup phase starts together with SETUP
              s_psel_q    <= sel_onehot;
              s_penable_q <= 1'b0;
              state_q     <= SETUP;
            end else begin
              state_q <= ERR;
            end
          end
        end
        SETUP: begin
          s_penable_q <= 1'b1;
          state_q     <= ACCESS;
        end
        ACCESS: begin
          // ready has priority over the watchdog
          if (sel_ready) begin
            cap_rdata_q <= sel_rdata;
            cap_err_q   <= sel_err;
            s_psel_q    <= '0;
            s_penable_q <= 1'b0;
            state_q     <= RESP;
          end else if (to_expired) begin
            s_psel_q    <= '0;
            s_penable_q <= 1'b0;
            state_q     <= ERR;
          end
        end
        RESP: begin
          m_pready_q  <= 1'b1;
          m_pslverr_q <= cap_err_q;
          m_prdata_q  <= write_q ? '0 : cap_rdata_q;
          state_q     <= IDLE;
        end
        ERR: begin
          m_pready_q  <= 1'b1;
          m_pslverr_q <= 1'b1;
          m_prdata_q  <= ERR_RDATA;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_psel_o    = s_psel_q;
  assign s_penable_o = s_penable_q;
  assign s_pwrite_o  = write_q;
  assign s_paddr_o   = addr_q;
  assign s_pwdata_o  = wdata_q;
  assign m_pready_o  = m_pready_q;
  assign m_pslverr_o = m_pslverr_q;
  assign m_prdata_o  = m_prdata_q;

`ifdef APB_PERIPH_DEMUX_ERR_LOG_EN
  logic                      log_hit;
  err_cause_e                log_cause;
  logic [APB_ADDR_WIDTH-1:0] log_addr;
  logic                      err_valid_q;
  err_cause_e                err_cause_q;
  logic [APB_ADDR_WIDTH-1:0] err_addr_q;

  // Error event of this cycle; at most one can occur per cycle
  always_comb begin
    log_hit   = 1'b0;
    log_cause = ERR_CAUSE_NONE;
    log_addr  = addr_q;
    if ((state_q == IDLE) && setup_req && !slot_ok) begin
      log_hit   = 1'b1;
      log_cause = ERR_CAUSE_DECODE;
      log_addr  = m_paddr_i;
    end else if ((state_q == ACCESS) && !sel_ready && to_expired) begin
      log_hit   = 1'b1;
      log_cause = ERR_CAUSE_TIMEOUT;
    end else if ((state_q == RESP) && cap_err_q) begin
      log_hit   = 1'b1;
      log_cause = ERR_CAUSE_SLVERR;
    end
  end

  // Sticky first-error log; a new error beats a simultaneous clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_q <= 1'b0;
      err_cause_q <= ERR_CAUSE_NONE;
      err_addr_q  <= '0;
    end else if (log_hit && (!err_valid_q || err_clr_i)) begin
      err_valid_q <= 1'b1;
      err_cause_q <= log_cause;
      err_addr_q  <= log_addr;
    end else if (err_clr_i) begin
      err_valid_q <= 1'b0;
      err_cause_q <= ERR_CAUSE_NONE;
      err_addr_q  <= '0;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_cause_o = err_cause_q;
  assign err_addr_o  = err_addr_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign err_valid_o    = 1'b0;
  assign err_cause_o    = 2'b00;
  assign err_addr_o     = '0;
`endif

endmodule

// File: doc/apb_periph_demux_to.md
Name: apb_periph_demux_to

Overview:
- Parametrised APB peripheral demultiplexer for the SoC peripheral subsystem. It sits between the AXI-to-APB bridge (single APB master port) and NB_SLAVES APB peripherals (UART, SoC control, future slots).
- Successor to the fixed 4-slot fan-out. It adds:
  - an enable mask for each slot;
  - decode-error response for unpopulated or out-of-range slots;
  - a per-transfer timeout watchdog, so a hung or tied-off slave can never stall the bridge.

Parameters:
- NB_SLAVES, 4, number of downstream APB slots.
- APB_ADDR_WIDTH, 12, APB address width.
- APB_DATA_WIDTH, 32, APB data width.
- SEL_LSB, 10, LSB of the slot-index field in paddr.
- SEL_WIDTH, 2, width of the slot-index field. Index = paddr[SEL_LSB+SEL_WIDTH-1:SEL_LSB].
- SLAVE_EN_MASK, 4'b1100, bit i=1 means slot i is populated.
- TIMEOUT_CYCLES, 256, maximum access-phase cycles before abort. Legal range 1..2^16.
- ERR_RDATA, 32'hBADC_AB1E, prdata returned on any error.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Synchronous, active-high.
- m_psel_i  in  1  master select.
- m_penable_i  in  1  master enable.
- m_pwrite_i  in  1  master write.
- m_paddr_i  in  APB_ADDR_WIDTH  master address.
- m_pwdata_i  in  APB_DATA_WIDTH  master write data.
- m_prdata_o  out  APB_DATA_WIDTH  read data to master.
- m_pready_o  out  1  ready to master.
- m_pslverr_o  out  1  error to master.
- s_psel_o  out  NB_SLAVES  one-hot slave select.
- s_penable_o  out  1  slave enable.
- s_pwrite_o  out  1  slave write.
- s_paddr_o  out  APB_ADDR_WIDTH  slave address.
- s_pwdata_o  out  APB_DATA_WIDTH  slave write data.
- s_prdata_i  in  NB_SLAVES x APB_DATA_WIDTH  slave read data.
- s_pready_i  in  NB_SLAVES  slave ready.
- s_pslverr_i  in  NB_SLAVES  slave error.
- err_valid_o  out  1  sticky error flag (optional feature).
- err_cause_o  out  2  00 none, 01 decode, 10 timeout, 11 slave pslverr.
- err_addr_o  out  APB_ADDR_WIDTH  address of first logged error.
- err_clr_i  in  1  clears the error log.

Behaviour:
- Reset values:
  - FSM state IDLE.
  - All outputs 0.
  - Timeout counter 0.
  - Latched address, data and index are 0.
- Downstream side is fully registered. Slave sees setup exactly 1 cycle after the state transition that selects it.
- IDLE:
  - On m_psel_i=1 with m_penable_i=0, latch paddr, pwdata, pwrite and index.
  - Index >= NB_SLAVES, or SLAVE_EN_MASK[index]=0 → ERR.
  - Otherwise → SETUP.
  - m_psel_i=1 with m_penable_i=1 in IDLE is a protocol violation. It is ignored; the FSM stays in IDLE.
- SETUP: s_psel_o[idx]=1, s_penable_o=0, for one cycle → ACCESS. Counter cleared.
- ACCESS:
  - s_psel_o[idx]=1, s_penable_o=1.
  - If s_pready_i[idx]=1: capture s_prdata_i[idx] and s_pslverr_i[idx] → RESP.
  - Else if counter == TIMEOUT_CYCLES-1 → ERR, with s_psel_o and s_penable_o deasserted next cycle.
  - Else counter+1. Counter is 16 bits and saturates; no wrap.
  - Ready and timeout in the same cycle: ready wins.
- RESP:
  - m_pready_o=1 for exactly one cycle.
  - m_prdata_o = captured data on reads, 0 on writes.
  - m_pslverr_o = captured pslverr.
  - → IDLE.
- ERR:
  - m_pready_o=1, m_pslverr_o=1, m_prdata_o=ERR_RDATA, for one cycle → IDLE.
- Outside RESP and ERR, m_pready_o=0, m_pslverr_o=0, m_prdata_o=0.
- Latency:
  - Decode error: master pready 2 cycles after setup.
  - Zero-wait slave: master pready 4 cycles after setup.
  - Timeout: master pready TIMEOUT_CYCLES+3 cycles after setup.
- Back-to-back transfers: a new master setup is accepted in the cycle the FSM is back in IDLE.
- Reset mid-transfer: FSM goes to IDLE next cycle. All s_psel_o and s_penable_o drop. The abandoned transfer produces no response.
- The late slave pready that follows an abort is ignored.

Optional Feature:
- Macro: APB_PERIPH_DEMUX_ERR_LOG_EN.
- With the macro defined:
  - On the first error while err_valid_o=0 (decode, timeout, or slave pslverr in RESP), set err_valid_o=1 and latch err_cause_o and err_addr_o.
  - Later errors do not overwrite the log.
  - err_clr_i=1 clears all three fields next cycle.
  - Clear and a new error in the same cycle: the new error is logged.
- Without the macro: err_valid_o, err_cause_o and err_addr_o are tied to 0, and err_clr_i is ignored.

Decomposition:
- Package apb_periph_demux_pkg contains:
  - state_e (IDLE, SETUP, ACCESS, RESP, ERR);
  - err_cause_e (2-bit);
  - ERR_CAUSE_* constants;
  - TO_CNT_WIDTH=16.
- One sub-module, apb_periph_to_cnt: a saturating timeout counter with clear, enable and expired outputs.

Test Plan:
- Read slot 3 (paddr=0xC04), slave pready immediate with prdata=0x1234_5678 → master pready at setup+4, prdata=0x1234_5678, pslverr=0.
- Write slot 0 (paddr=0x010, masked off) → no s_psel_o activity; pready at setup+2 with pslverr=1, prdata=0xBADC_AB1E, log cause=01, addr=0x010.
- Read slot 2 with TIMEOUT_CYCLES=8, slave pready held 0 → s_psel_o[2] drops after 8 access cycles; master pslverr=1, log cause=10.
- Slave asserts pready in the last allowed cycle together with pslverr=1 → normal RESP with pslverr=1, no timeout logged, log cause=11.
- Assert rst_i during ACCESS → next cycle all outputs 0, FSM IDLE; a following read to slot 3 completes normally.
- Two errors, then err_clr_i → first error retained until clear; clear and third error in the same cycle → third error logged.
